// File: rtl/rat_control_unit_irq.sv
// Multicycle RAT control unit with prioritised interrupts, SCR read wait states
// and illegal-opcode detection. All outputs are combinational from state, opcode and flags.
module rat_control_unit_irq #(
  parameter int NUM_IRQ  = 4,
  parameter int SCR_WAIT = 0,
  parameter int IRQ_ID_W = 3
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic [4:0]          OPCODE_HI_5,
  input  logic [1:0]          OPCODE_LOW_2,
  input  logic [NUM_IRQ-1:0]  INTR,
  input  logic                I_FLAG,
  input  logic                C_FLAG,
  input  logic                Z_FLAG,
  output logic                PC_LD,
  output logic                PC_INC,
  output logic [1:0]          PC_MUX_SEL,
  output logic                ALU_OPY_SEL,
  output logic [3:0]          ALU_SEL,
  output logic                RF_WR,
  output logic [1:0]          RF_WR_SEL,
  output logic                FLG_C_SET,
  output logic                FLG_C_CLR,
  output logic                FLG_C_LD,
  output logic                FLG_Z_LD,
  output logic                FLG_SHAD_LD,
  output logic                FLG_LD_SEL,
  output logic                I_SET,
  output logic                I_CLR,
  output logic                RST,
  output logic                IO_STRB,
  output logic                SP_LD,
  output logic                SP_INCR,
  output logic                SP_DECR,
  output logic                SCR_WE,
  output logic [1:0]          SCR_ADDR_SEL,
  output logic                SCR_DATA_SEL,
  output logic                IRQ_ACK,
  output logic [IRQ_ID_W-1:0] IRQ_ID,
  output logic                ILLEGAL
);

  typedef enum logic [2:0] {
    ST_INIT  = 3'd0,
    ST_FETCH = 3'd1,
    ST_EXEC  = 3'd2,
    ST_WAIT  = 3'd3,
    ST_INTR  = 3'd4
  } state_t;

  typedef struct packed {
    logic       pc_ld;
    logic       pc_inc;
    logic [1:0] pc_mux_sel;
    logic       alu_opy_sel;
    logic [3:0] alu_sel;
    logic       rf_wr;
    logic [1:0] rf_wr_sel;
    logic       flg_c_set;
    logic       flg_c_clr;
    logic       flg_c_ld;
    logic       flg_z_ld;
    logic       flg_shad_ld;
    logic       flg_ld_sel;
    logic       i_set;
    logic       i_clr;
    logic       rst;
    logic       io_strb;
    logic       sp_ld;
    logic       sp_incr;
    logic       sp_decr;
    logic       scr_we;
    logic [1:0] scr_addr_sel;
    logic       scr_data_sel;
  } ctrl_t;

  localparam logic [2:0] WAIT_LAST = 3'((SCR_WAIT > 0) ? SCR_WAIT - 1 : 0);

  state_t state, next_state;
  logic [2:0] wait_cnt;
  ctrl_t dec, sel_only, ctrl;
  logic scr_rd, illegal_op, complete, irq_ack;
  logic [IRQ_ID_W-1:0] irq_sel;

  function automatic ctrl_t alu_op(input logic [3:0] sel, input logic wr,
                                   input logic imm, input logic flg);
    ctrl_t c;
    c = '0;
    c.alu_sel     = sel;
    c.rf_wr       = wr;
    c.alu_opy_sel = imm;
    c.flg_c_ld    = flg;
    c.flg_z_ld    = flg;
    return c;
  endfunction

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state    <= ST_INIT;
      wait_cnt <= 3'd0;
    end else begin
      state    <= next_state;
      wait_cnt <= (state == ST_WAIT) ? wait_cnt + 3'd1 : 3'd0;
    end
  end

  // Full single-cycle control word for the current opcode.
  always_comb begin
    dec        = '0;
    scr_rd     = 1'b0;
    illegal_op = 1'b0;
    casez ({OPCODE_HI_5, OPCODE_LOW_2})
      7'b00000_00: dec = alu_op(4'd5,  1'b1, 1'b0, 1'b1);
      7'b00000_01: dec = alu_op(4'd6,  1'b1, 1'b0, 1'b1);
      7'b00000_10: dec = alu_op(4'd7,  1'b1, 1'b0, 1'b1);
      7'b00000_11: dec = alu_op(4'd8,  1'b0, 1'b0, 1'b1);
      7'b00001_00: dec = alu_op(4'd0,  1'b1, 1'b0, 1'b1);
      7'b00001_01: dec = alu_op(4'd1,  1'b1, 1'b0, 1'b1);
      7'b00001_10: dec = alu_op(4'd2,  1'b1, 1'b0, 1'b1);
      7'b00001_11: dec = alu_op(4'd3,  1'b1, 1'b0, 1'b1);
      7'b00010_00: dec = alu_op(4'd4,  1'b0, 1'b0, 1'b1);
      7'b00010_01: dec = alu_op(4'd14, 1'b1, 1'b0, 1'b0);
      7'b00010_10: begin
        dec.rf_wr     = 1'b1;
        dec.rf_wr_sel = 2'd1;
        scr_rd        = 1'b1;
      end
      7'b00010_11: dec.scr_we = 1'b1;
      7'b00100_00: dec.pc_ld = 1'b1;
      7'b00100_01: begin
        dec.pc_ld        = 1'b1;
        dec.scr_we       = 1'b1;
        dec.scr_addr_sel = 2'd3;
        dec.scr_data_sel = 1'b1;
        dec.sp_decr      = 1'b1;
      end
      7'b00100_10: dec.pc_ld = Z_FLAG;
      7'b00100_11: dec.pc_ld = ~Z_FLAG;
      7'b00101_00: dec.pc_ld = C_FLAG;
      7'b00101_01: dec.pc_ld = ~C_FLAG;
      7'b01000_00: dec = alu_op(4'd9,  1'b1, 1'b0, 1'b1);
      7'b01000_01: dec = alu_op(4'd10, 1'b1, 1'b0, 1'b1);
      7'b01000_10: dec = alu_op(4'd11, 1'b1, 1'b0, 1'b1);
      7'b01000_11: dec = alu_op(4'd12, 1'b1, 1'b0, 1'b1);
      7'b01001_00: dec = alu_op(4'd13, 1'b1, 1'b0, 1'b1);
      7'b01001_01: begin
        dec.scr_we       = 1'b1;
        dec.scr_addr_sel = 2'd3;
        dec.sp_decr      = 1'b1;
      end
      7'b01001_10: begin
        dec.rf_wr        = 1'b1;
        dec.rf_wr_sel    = 2'd1;
        dec.scr_addr_sel = 2'd2;
        dec.sp_incr      = 1'b1;
        scr_rd           = 1'b1;
      end
      7'b01010_00: dec.sp_ld = 1'b1;
      7'b01010_01: begin
        dec.rf_wr     = 1'b1;
        dec.rf_wr_sel = 2'd2;
      end
      7'b01100_00: dec.flg_c_clr = 1'b1;
      7'b01100_01: dec.flg_c_set = 1'b1;
      7'b01100_10: begin
        dec.pc_ld        = 1'b1;
        dec.pc_mux_sel   = 2'd1;
        dec.scr_addr_sel = 2'd2;
        dec.sp_incr      = 1'b1;
        scr_rd           = 1'b1;
      end
      7'b01101_00: dec.i_set = 1'b1;
      7'b01101_01: dec.i_clr = 1'b1;
      7'b01101_1?: begin
        // RETID / RETIE: pop PC and restore shadow flags; LSB picks I state.
        dec.pc_ld        = 1'b1;
        dec.pc_mux_sel   = 2'd1;
        dec.scr_addr_sel = 2'd2;
        dec.sp_incr      = 1'b1;
        dec.flg_ld_sel   = 1'b1;
        dec.flg_c_ld     = 1'b1;
        dec.flg_z_ld     = 1'b1;
        dec.i_set        = OPCODE_LOW_2[0];
        dec.i_clr        = ~OPCODE_LOW_2[0];
        scr_rd           = 1'b1;
      end
      7'b10000_??: dec = alu_op(4'd5,  1'b1, 1'b1, 1'b1);
      7'b10001_??: dec = alu_op(4'd6,  1'b1, 1'b1, 1'b1);
      7'b10010_??: dec = alu_op(4'd7,  1'b1, 1'b1, 1'b1);
      7'b10011_??: dec = alu_op(4'd8,  1'b0, 1'b1, 1'b1);
      7'b10100_??: dec = alu_op(4'd0,  1'b1, 1'b1, 1'b1);
      7'b10101_??: dec = alu_op(4'd1,  1'b1, 1'b1, 1'b1);
      7'b10110_??: dec = alu_op(4'd2,  1'b1, 1'b1, 1'b1);
      7'b10111_??: dec = alu_op(4'd3,  1'b1, 1'b1, 1'b1);
      7'b11000_??: dec = alu_op(4'd4,  1'b0, 1'b1, 1'b1);
      7'b11001_??: begin
        dec.rf_wr     = 1'b1;
        dec.rf_wr_sel = 2'd3;
      end
      7'b11010_??: dec.io_strb = 1'b1;
      7'b11011_??: dec = alu_op(4'd14, 1'b1, 1'b1, 1'b0);
      7'b11100_??: begin
        dec.rf_wr        = 1'b1;
        dec.rf_wr_sel    = 2'd1;
        dec.scr_addr_sel = 2'd1;
        scr_rd           = 1'b1;
      end
      7'b11101_??: begin
        dec.scr_we       = 1'b1;
        dec.scr_addr_sel = 2'd1;
      end
      default: illegal_op = 1'b1;
    endcase
  end

  // Selects held steady while SCR read data settles; strobes withheld.
  always_comb begin
    sel_only              = '0;
    sel_only.scr_addr_sel = dec.scr_addr_sel;
    sel_only.pc_mux_sel   = dec.pc_mux_sel;
    sel_only.rf_wr_sel    = dec.rf_wr_sel;
    sel_only.flg_ld_sel   = dec.flg_ld_sel;
  end

  always_comb begin
    irq_sel = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--)
      if (INTR[i]) irq_sel = IRQ_ID_W'(i);
  end

  always_comb begin
    ctrl       = '0;
    next_state = state;
    complete   = 1'b0;
    irq_ack    = 1'b0;
    ILLEGAL    = 1'b0;
    case (state)
      ST_INIT: begin
        ctrl.rst   = 1'b1;
        next_state = ST_FETCH;
      end
      ST_FETCH: begin
        ctrl.pc_inc = 1'b1;
        next_state  = ST_EXEC;
      end
      ST_EXEC: begin
        ILLEGAL = illegal_op;
        if (SCR_WAIT > 0 && scr_rd) begin
          ctrl       = sel_only;
          next_state = ST_WAIT;
        end else begin
          ctrl     = dec;
          complete = 1'b1;
        end
      end
      ST_WAIT: begin
        if (wait_cnt == WAIT_LAST) begin
          ctrl     = dec;
          complete = 1'b1;
        end else begin
          ctrl = sel_only;
        end
      end
      ST_INTR: begin
        ctrl.pc_ld        = 1'b1;
        ctrl.pc_mux_sel   = 2'd2;
        ctrl.scr_we       = 1'b1;
        ctrl.scr_addr_sel = 2'd3;
        ctrl.scr_data_sel = 1'b1;
        ctrl.sp_decr      = 1'b1;
        ctrl.i_clr        = 1'b1;
        ctrl.flg_shad_ld  = 1'b1;
        irq_ack           = 1'b1;
        next_state        = ST_FETCH;
      end
      default: next_state = ST_INIT;
    endcase
    // Registered I_FLAG: an instruction that clears I still lets one IRQ through.
    if (complete)
      next_state = ((|INTR) && I_FLAG) ? ST_INTR : ST_FETCH;
  end

  assign PC_LD        = ctrl.pc_ld;
  assign PC_INC       = ctrl.pc_inc;
  assign PC_MUX_SEL   = ctrl.pc_mux_sel;
  assign ALU_OPY_SEL  = ctrl.alu_opy_sel;
  assign ALU_SEL      = ctrl.alu_sel;
  assign RF_WR        = ctrl.rf_wr;
  assign RF_WR_SEL    = ctrl.rf_wr_sel;
  assign FLG_C_SET    = ctrl.flg_c_set;
  assign FLG_C_CLR    = ctrl.flg_c_clr;
  assign FLG_C_LD     = ctrl.flg_c_ld;
  assign FLG_Z_LD     = ctrl.flg_z_ld;
  assign FLG_SHAD_LD  = ctrl.flg_shad_ld;
  assign FLG_LD_SEL   = ctrl.flg_ld_sel;
  assign I_SET        = ctrl.i_set;
  assign I_CLR        = ctrl.i_clr;
  assign RST          = ctrl.rst;
  assign IO_STRB      = ctrl.io_strb;
  assign SP_LD        = ctrl.sp_ld;
  assign SP_INCR      = ctrl.sp_incr;
  assign SP_DECR      = ctrl.sp_decr;
  assign SCR_WE       = ctrl.scr_we;
  assign SCR_ADDR_SEL = ctrl.scr_addr_sel;
  assign SCR_DATA_SEL = ctrl.scr_data_sel;
  assign IRQ_ACK      = irq_ack;
  assign IRQ_ID       = irq_ack ? irq_sel : '0;

endmodule

// File: tb/tb_rat_control_unit_irq.sv
// Directed bench: one unit with no SCR wait states (a) and one with two (b),
// driven by the same inputs; every output word compared against hand-built values.
module tb_rat_control_unit_irq;

  typedef struct packed {
    logic       pc_ld;
    logic       pc_inc;
    logic [1:0] pc_mux_sel;
    logic       alu_opy_sel;
    logic [3:0] alu_sel;
    logic       rf_wr;
    logic [1:0] rf_wr_sel;
    logic       flg_c_set;
    logic       flg_c_clr;
    logic       flg_c_ld;
    logic       flg_z_ld;
    logic       flg_shad_ld;
    logic       flg_ld_sel;
    logic       i_set;
    logic       i_clr;
    logic       rst;
    logic       io_strb;
    logic       sp_ld;
    logic       sp_incr;
    logic       sp_decr;
    logic       scr_we;
    logic [1:0] scr_addr_sel;
    logic       scr_data_sel;
    logic       irq_ack;
    logic [2:0] irq_id;
    logic       illegal;
  } ctl_t;

  logic       CLK, RESET, I_FLAG, C_FLAG, Z_FLAG;
  logic [4:0] hi;
  logic [1:0] lo;
  logic [3:0] INTR;
  int total = 0;
  int bad   = 0;

  logic pc_ld_a, pc_inc_a, opy_a, rf_wr_a, c_set_a, c_clr_a, c_ld_a, z_ld_a, shad_a, ld_sel_a;
  logic i_set_a, i_clr_a, rst_a, io_a, sp_ld_a, sp_inc_a, sp_dec_a, scr_we_a, scr_ds_a, ack_a, ill_a;
  logic [1:0] pc_mux_a, wr_sel_a, scr_as_a;
  logic [3:0] alu_a;
  logic [2:0] id_a;
  logic pc_ld_b, pc_inc_b, opy_b, rf_wr_b, c_set_b, c_clr_b, c_ld_b, z_ld_b, shad_b, ld_sel_b;
  logic i_set_b, i_clr_b, rst_b, io_b, sp_ld_b, sp_inc_b, sp_dec_b, scr_we_b, scr_ds_b, ack_b, ill_b;
  logic [1:0] pc_mux_b, wr_sel_b, scr_as_b;
  logic [3:0] alu_b;
  logic [2:0] id_b;
  ctl_t oa, ob, e;

  assign oa = {pc_ld_a, pc_inc_a, pc_mux_a, opy_a, alu_a, rf_wr_a, wr_sel_a, c_set_a, c_clr_a,
               c_ld_a, z_ld_a, shad_a, ld_sel_a, i_set_a, i_clr_a, rst_a, io_a, sp_ld_a,
               sp_inc_a, sp_dec_a, scr_we_a, scr_as_a, scr_ds_a, ack_a, id_a, ill_a};
  assign ob = {pc_ld_b, pc_inc_b, pc_mux_b, opy_b, alu_b, rf_wr_b, wr_sel_b, c_set_b, c_clr_b,
               c_ld_b, z_ld_b, shad_b, ld_sel_b, i_set_b, i_clr_b, rst_b, io_b, sp_ld_b,
               sp_inc_b, sp_dec_b, scr_we_b, scr_as_b, scr_ds_b, ack_b, id_b, ill_b};

  rat_control_unit_irq #(.NUM_IRQ(4), .SCR_WAIT(0), .IRQ_ID_W(3)) u_a (
    .CLK(CLK), .RESET(RESET), .OPCODE_HI_5(hi), .OPCODE_LOW_2(lo), .INTR(INTR),
    .I_FLAG(I_FLAG), .C_FLAG(C_FLAG), .Z_FLAG(Z_FLAG),
    .PC_LD(pc_ld_a), .PC_INC(pc_inc_a), .PC_MUX_SEL(pc_mux_a), .ALU_OPY_SEL(opy_a),
    .ALU_SEL(alu_a), .RF_WR(rf_wr_a), .RF_WR_SEL(wr_sel_a), .FLG_C_SET(c_set_a),
    .FLG_C_CLR(c_clr_a), .FLG_C_LD(c_ld_a), .FLG_Z_LD(z_ld_a), .FLG_SHAD_LD(shad_a),
    .FLG_LD_SEL(ld_sel_a), .I_SET(i_set_a), .I_CLR(i_clr_a), .RST(rst_a), .IO_STRB(io_a),
    .SP_LD(sp_ld_a), .SP_INCR(sp_inc_a), .SP_DECR(sp_dec_a), .SCR_WE(scr_we_a),
    .SCR_ADDR_SEL(scr_as_a), .SCR_DATA_SEL(scr_ds_a), .IRQ_ACK(ack_a), .IRQ_ID(id_a),
    .ILLEGAL(ill_a));

  rat_control_unit_irq #(.NUM_IRQ(4), .SCR_WAIT(2), .IRQ_ID_W(3)) u_b (
    .CLK(CLK), .RESET(RESET), .OPCODE_HI_5(hi), .OPCODE_LOW_2(lo), .INTR(INTR),
    .I_FLAG(I_FLAG), .C_FLAG(C_FLAG), .Z_FLAG(Z_FLAG),
    .PC_LD(pc_ld_b), .PC_INC(pc_inc_b), .PC_MUX_SEL(pc_mux_b), .ALU_OPY_SEL(opy_b),
    .ALU_SEL(alu_b), .RF_WR(rf_wr_b), .RF_WR_SEL(wr_sel_b), .FLG_C_SET(c_set_b),
    .FLG_C_CLR(c_clr_b), .FLG_C_LD(c_ld_b), .FLG_Z_LD(z_ld_b), .FLG_SHAD_LD(shad_b),
    .FLG_LD_SEL(ld_sel_b), .I_SET(i_set_b), .I_CLR(i_clr_b), .RST(rst_b), .IO_STRB(io_b),
    .SP_LD(sp_ld_b), .SP_INCR(sp_inc_b), .SP_DECR(sp_dec_b), .SCR_WE(scr_we_b),
    .SCR_ADDR_SEL(scr_as_b), .SCR_DATA_SEL(scr_ds_b), .IRQ_ACK(ack_b), .IRQ_ID(id_b),
    .ILLEGAL(ill_b));

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  task automatic chk(input string tag, input ctl_t obs, input ctl_t exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, obs, exp);
    end
  endtask

  function automatic ctl_t x_rst();
    ctl_t c = '0;
    c.rst = 1'b1;
    return c;
  endfunction

  function automatic ctl_t x_fetch();
    ctl_t c = '0;
    c.pc_inc = 1'b1;
    return c;
  endfunction

  function automatic ctl_t x_intr(input logic [2:0] id);
    ctl_t c = '0;
    c.pc_ld = 1'b1;  c.pc_mux_sel = 2'd2; c.scr_we = 1'b1; c.scr_addr_sel = 2'd3;
    c.scr_data_sel = 1'b1; c.sp_decr = 1'b1; c.i_clr = 1'b1; c.flg_shad_ld = 1'b1;
    c.irq_ack = 1'b1; c.irq_id = id;
    return c;
  endfunction

  function automatic ctl_t x_pop_sel();
    ctl_t c = '0;
    c.scr_addr_sel = 2'd2; c.rf_wr_sel = 2'd1;
    return c;
  endfunction

  function automatic ctl_t x_pop();
    ctl_t c = '0;
    c.rf_wr = 1'b1; c.rf_wr_sel = 2'd1; c.scr_addr_sel = 2'd2; c.sp_incr = 1'b1;
    return c;
  endfunction

  function automatic ctl_t x_reti_sel();
    ctl_t c = '0;
    c.pc_mux_sel = 2'd1; c.scr_addr_sel = 2'd2; c.flg_ld_sel = 1'b1;
    return c;
  endfunction

  function automatic ctl_t x_retie();
    ctl_t c = '0;
    c.pc_ld = 1'b1; c.pc_mux_sel = 2'd1; c.scr_addr_sel = 2'd2; c.sp_incr = 1'b1;
    c.flg_ld_sel = 1'b1; c.flg_c_ld = 1'b1; c.flg_z_ld = 1'b1; c.i_set = 1'b1;
    return c;
  endfunction

  initial begin
    RESET = 1'b1; hi = 5'b0; lo = 2'b0; INTR = 4'b0; I_FLAG = 1'b0; C_FLAG = 1'b0; Z_FLAG = 1'b0;
    #1 RESET = 1'b0;
    #1;
    chk("rst_hold_a", oa, x_rst());
    chk("rst_hold_b", ob, x_rst());
    repeat (3) @(posedge CLK);
    #2 RESET = 1'b1;
    #1 chk("post_rst_init", oa, x_rst());

    tick(); hi = 5'b10100; lo = 2'b00;
    #1 chk("first_fetch", oa, x_fetch());
    tick(); #1;
    e = '0; e.rf_wr = 1'b1; e.alu_opy_sel = 1'b1; e.flg_c_ld = 1'b1; e.flg_z_ld = 1'b1;
    chk("add_imm_a", oa, e);
    chk("add_imm_b", ob, e);

    // MOV with two requests pending: index 1 beats index 2.
    tick(); hi = 5'b00010; lo = 2'b01; I_FLAG = 1'b1; INTR = 4'b0110;
    #1 chk("add_to_fetch", oa, x_fetch());
    tick(); #1;
    e = '0; e.rf_wr = 1'b1; e.alu_sel = 4'd14;
    chk("mov_exec", oa, e);
    tick(); #1;
    chk("intr_id1_a", oa, x_intr(3'd1));
    chk("intr_id1_b", ob, x_intr(3'd1));

    tick(); hi = 5'b01101; lo = 2'b00; I_FLAG = 1'b0; INTR = 4'b0001;
    #1 chk("intr_to_fetch", oa, x_fetch());
    tick(); #1;
    e = '0; e.i_set = 1'b1;
    chk("sei_exec", oa, e);
    tick(); hi = 5'b01101; lo = 2'b01; I_FLAG = 1'b1; INTR = 4'b1100;
    #1 chk("sei_no_irq", oa, x_fetch());
    tick(); #1;
    e = '0; e.i_clr = 1'b1;
    chk("cli_exec", oa, e);
    tick(); #1 chk("cli_intr_id2", oa, x_intr(3'd2));

    tick(); hi = 5'b01100; lo = 2'b00; INTR = 4'b1000;
    #1 chk("fetch_clc", oa, x_fetch());
    tick(); #1;
    e = '0; e.flg_c_clr = 1'b1;
    chk("clc_exec", oa, e);
    tick(); #1 chk("intr_id3", oa, x_intr(3'd3));

    tick(); hi = 5'b00100; lo = 2'b10; INTR = 4'b0; I_FLAG = 1'b0; Z_FLAG = 1'b0;
    #1 chk("fetch_breq", oa, x_fetch());
    tick(); #1 chk("breq_not_taken", oa, ctl_t'(0));
    Z_FLAG = 1'b1;
    #1;
    e = '0; e.pc_ld = 1'b1;
    chk("breq_taken", oa, e);
    hi = 5'b00101; lo = 2'b01; C_FLAG = 1'b1;
    #1 chk("brcc_not_taken", oa, ctl_t'(0));
    C_FLAG = 1'b0;
    #1 chk("brcc_taken", oa, e);
    Z_FLAG = 1'b0;

    tick(); hi = 5'b01101; lo = 2'b11;
    #1 chk("fetch_retie", oa, x_fetch());
    tick(); #1;
    chk("retie_exec_a", oa, x_retie());
    chk("retie_sel_b", ob, x_reti_sel());
    tick(); #1;
    chk("retie_a_fetch", oa, x_fetch());
    chk("retie_wait1_b", ob, x_reti_sel());
    tick(); #1;
    chk("retie_wait2_b", ob, x_retie());
    hi = 5'b11111; lo = 2'b11;
    #1;
    e = '0; e.illegal = 1'b1;
    chk("illegal_exec", oa, e);
    tick(); #1 chk("illegal_continues", oa, x_fetch());

    // POP on the wait-state unit, then a reset landing mid-WAIT.
    RESET = 1'b0;
    #1;
    chk("rst_again_a", oa, x_rst());
    chk("rst_again_b", ob, x_rst());
    tick(); RESET = 1'b1; hi = 5'b01001; lo = 2'b10;
    tick(); #1 chk("pop_fetch_b", ob, x_fetch());
    tick(); #1;
    chk("pop_exec_a", oa, x_pop());
    chk("pop_exec_b", ob, x_pop_sel());
    tick(); #1 chk("pop_wait1_b", ob, x_pop_sel());
    tick(); #1 chk("pop_wait2_b", ob, x_pop());
    tick(); #1 chk("pop_done_fetch_b", ob, x_fetch());
    tick(); tick();
    RESET = 1'b0; I_FLAG = 1'b1; INTR = 4'b0001;
    #1 chk("rst_mid_wait", ob, x_rst());
    tick(); RESET = 1'b1;
    tick(); tick(); #1 chk("pop2_exec_b", ob, x_pop_sel());
    tick(); #1 chk("pop2_wait1_b", ob, x_pop_sel());
    tick(); #1 chk("pop2_wait2_b", ob, x_pop());
    tick(); #1 chk("pop2_intr_id0", ob, x_intr(3'd0));
    tick(); INTR = 4'b0; I_FLAG = 1'b0;
    #1 chk("pop2_intr_fetch", ob, x_fetch());

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rat_control_unit_irq.md
Name: rat_control_unit_irq

Overview:
- Parametrised successor to the RAT multicycle control unit; decodes the full RAT ISA, including the interrupt instructions SEI, CLI, RETID, RETIE and RSP.
- Adds a prioritised multi-source interrupt cycle, configurable scratch-RAM read wait states, and an illegal-opcode flag.
- Sits between prog_rom opcode fields, flag registers, PC, SP, SCR and the register file.

Parameters:
NUM_IRQ, 4, number of interrupt request lines (1..8).
SCR_WAIT, 0, extra cycles inserted after EXEC for SCR-read instructions (0..7).
IRQ_ID_W, 3, width of IRQ_ID output; must be at least clog2(NUM_IRQ), minimum 1.

Ports:
CLK  in  1  system clock, rising edge.
RESET  in  1  asynchronous, active-low reset (0 = reset).
OPCODE_HI_5  in  5  instruction bits [17:13].
OPCODE_LOW_2  in  2  instruction bits [1:0].
INTR  in  NUM_IRQ  level-sensitive requests; bit 0 has highest priority.
I_FLAG  in  1  registered interrupt-enable flag.
C_FLAG, Z_FLAG  in  1 each  registered flags.
PC_LD, PC_INC  out  1 each  PC control.
PC_MUX_SEL  out  2  PC source: 0 = immediate, 1 = SCR data, 2 = interrupt vector.
ALU_OPY_SEL  out  1  ALU Y operand: 0 = register, 1 = immediate.
ALU_SEL  out  4  ALU operation code.
RF_WR  out  1  register-file write enable.
RF_WR_SEL  out  2  register-file write source: 0 = ALU, 1 = SCR, 2 = SP, 3 = IN_PORT.
FLG_C_SET, FLG_C_CLR, FLG_C_LD, FLG_Z_LD  out  1 each  flag controls.
FLG_SHAD_LD, FLG_LD_SEL  out  1 each  shadow-flag save; flag-load source select (1 = shadow).
I_SET, I_CLR  out  1 each  interrupt-enable flag controls.
RST  out  1  datapath reset.
IO_STRB  out  1  output-port strobe.
SP_LD, SP_INCR, SP_DECR  out  1 each  stack-pointer controls.
SCR_WE  out  1  scratch-RAM write enable.
SCR_ADDR_SEL  out  2  SCR address: 0 = reg, 1 = imm, 2 = SP, 3 = SP-1.
SCR_DATA_SEL  out  1  SCR write data: 0 = register, 1 = PC.
IRQ_ACK  out  1  pulse during the interrupt cycle.
IRQ_ID  out  IRQ_ID_W  index of the serviced source; valid while IRQ_ACK = 1, otherwise 0.
ILLEGAL  out  1  pulse in EXEC for an undefined opcode.

Behaviour:
- States: ST_INIT, ST_FETCH, ST_EXEC, ST_WAIT, ST_INTR. RESET = 0 forces ST_INIT asynchronously; the state register and the wait counter clear to 0.
- All outputs are combinational from state, opcode and flags. Every output defaults to 0 in every state; the rules below list only the signals that are asserted.
- ST_INIT: RST = 1; next state ST_FETCH.
- ST_FETCH: PC_INC = 1; next state ST_EXEC.
- ST_EXEC decode:
  - Register and immediate ALU instructions, CMP, IN, OUT, MOV, LD, ST, branches, CALL, shifts, PUSH, POP, WSP, CLC, SEC and RET use the existing RAT encodings and control values.
  - ALU_SEL codes: ADD 0, ADDC 1, SUB 2, SUBC 3, CMP 4, AND 5, OR 6, EXOR 7, TEST 8, LSL 9, LSR 10, ROL 11, ROR 12, ASR 13, MOV 14.
  - RSP (01010_01): RF_WR = 1, RF_WR_SEL = 2.
  - SEI (01101_00): I_SET = 1. CLI (01101_01): I_CLR = 1.
  - RETID (01101_10) and RETIE (01101_11) both assert: PC_LD, PC_MUX_SEL = 1, SCR_ADDR_SEL = 2, SP_INCR, FLG_LD_SEL, FLG_C_LD, FLG_Z_LD.
  - RETID additionally asserts I_CLR; RETIE additionally asserts I_SET.
  - Conditional branches (BREQ, BRNE, BRCS, BRCC) assert PC_LD only when the flag condition holds.
  - Undefined opcode: ILLEGAL = 1, no other control asserted, execution continues normally (RST is not asserted).
- SCR-read instructions are LD (both forms), POP, RET, RETID and RETIE.
  - With SCR_WAIT = N > 0: EXEC drives SCR_ADDR_SEL, PC_MUX_SEL, RF_WR_SEL and FLG_LD_SEL only.
  - ST_WAIT then holds those select signals for N cycles, counted by a 3-bit counter.
  - The write/load strobes (RF_WR, PC_LD, SP_INCR, FLG_*_LD, I_SET/I_CLR) assert only in the final ST_WAIT cycle.
  - With N = 0 the instruction completes in EXEC.
- Completion point = EXEC for single-cycle instructions, or the final WAIT cycle.
  - If (|INTR) && I_FLAG at completion: next state ST_INTR. Otherwise: next state ST_FETCH.
  - I_FLAG is the registered value, so SEI takes effect after the following instruction completes. CLI/RETID, however, still permit an interrupt at their own completion if I_FLAG was 1.
- ST_INTR asserts:
  - PC_LD, PC_MUX_SEL = 2;
  - SCR_WE, SCR_ADDR_SEL = 3, SCR_DATA_SEL = 1, SP_DECR (push PC);
  - I_CLR, FLG_SHAD_LD, IRQ_ACK;
  - IRQ_ID = lowest-index set bit of INTR.
  - Next state ST_FETCH.
- Simultaneous requests: lowest index wins; the others remain pending because INTR is level-sensitive. INTR deasserting before completion loses the request.
- Reset mid-WAIT or mid-INTR: abandons the operation immediately, with no strobes on the reset edge.

Test Plan:
- Hold RESET = 0 for 3 cycles, then release: RST = 1 in the first post-reset cycle, PC_INC = 1 in the next, all other outputs 0.
- ADD immediate (10100), SCR_WAIT = 0: EXEC shows FLG_C_LD = FLG_Z_LD = RF_WR = ALU_OPY_SEL = 1, ALU_SEL = 0; the next state is FETCH.
- POP with SCR_WAIT = 2: EXEC SCR_ADDR_SEL = 2, RF_WR = 0; WAIT cycle 1 no strobes; WAIT cycle 2 RF_WR = 1, RF_WR_SEL = 1, SP_INCR = 1; total 4 cycles FETCH to FETCH.
- I_FLAG = 1, INTR = 4'b0110 during MOV: next cycle ST_INTR with IRQ_ACK = 1, IRQ_ID = 1, PC_MUX_SEL = 2, SCR_WE = 1, SP_DECR = 1, I_CLR = 1, FLG_SHAD_LD = 1.
- I_FLAG = 0, INTR = 4'b0001 during SEI: I_SET = 1, next state FETCH, no IRQ_ACK.
- RETIE: PC_LD = 1, PC_MUX_SEL = 1, SP_INCR = 1, FLG_LD_SEL = 1, I_SET = 1. Opcode 11111_11: ILLEGAL = 1, RST = 0.
